// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle MIPS multiply/divide unit with architectural HI/LO registers.
//   clock    rising-edge clock
//   reset    asynchronous, active-low
//   start    request a new operation (accepted only in IDLE)
//   op       0=MULT, 1=MULTU, 2=DIV, 3=DIVU
//   inA/inB  rs/rt operands (multiplicand/dividend, multiplier/divisor)
//   hi_wen/lo_wen/wd  mthi/mtlo write port, honoured only in IDLE
//   busy     high while an operation is in CALC or FINISH
//   done     one-cycle pulse once HI/LO hold a new result
//   hi/lo    HI and LO registers
//   div_zero (only with `define MDU_DIV_ZERO_FLAG_EN) last DIV/DIVU had a zero divisor
module mult_div_unit #(
  parameter int N = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] inA,
  input  logic [N-1:0] inB,
  input  logic         hi_wen,
  input  logic         lo_wen,
  input  logic [N-1:0] wd,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
`ifdef MDU_DIV_ZERO_FLAG_EN
  ,
  output logic         div_zero
`endif
);
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
  state_t state, state_next;
  logic [CW-1:0] cnt;
  logic is_div, sign_a, sign_b;
  logic [N-1:0] a_raw, a_mag, b_mag, rem, q;
  logic signed_op;
  logic [N-1:0] in_a_mag, in_b_mag;
  logic [N:0] m_sum, d_shift;
  logic [N-1:0] d_diff;
  logic d_ge, b_zero;
  logic [2*N-1:0] prod, prod_fix;
  logic [N-1:0] quo_fix, rem_fix, res_hi, res_lo;
  assign busy = state != IDLE;
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = start ? CALC : IDLE;
      CALC:    state_next = (cnt == CW'(N - 1)) ? FINISH : CALC;
      default: state_next = IDLE;
    endcase
  end
  // Multiply keeps the partial product in {rem, q}: q starts as the multiplier and
  // shifts out one bit per cycle while product bits shift in from the top.
  // Divide keeps the partial remainder in rem and shifts quotient bits into q.
  always_comb begin
    signed_op = ~op[0];
    in_a_mag = (signed_op && inA[N-1]) ? -inA : inA;
    in_b_mag = (signed_op && inB[N-1]) ? -inB : inB;
    m_sum = {1'b0, rem} + {1'b0, q[0] ? a_mag : {N{1'b0}}};
    d_shift = {rem, q[N-1]};
    d_ge = d_shift >= {1'b0, b_mag};
    d_diff = d_shift[N-1:0] - b_mag;
    b_zero = b_mag == '0;
    prod = {rem, q};
    prod_fix = (sign_a ^ sign_b) ? -prod : prod;
    quo_fix = (sign_a ^ sign_b) ? -q : q;
    rem_fix = sign_a ? -rem : rem;
    res_hi = is_div ? (b_zero ? a_raw : rem_fix) : prod_fix[2*N-1:N];
    res_lo = is_div ? (b_zero ? {N{1'b1}} : quo_fix) : prod_fix[N-1:0];
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      is_div <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      a_raw <= '0;
      a_mag <= '0;
      b_mag <= '0;
      rem <= '0;
      q <= '0;
      hi <= '0;
      lo <= '0;
      done <= 1'b0;
    end else begin
      done <= state == FINISH;
      if (state == IDLE) begin
        if (hi_wen) hi <= wd;
        if (lo_wen) lo <= wd;
        if (start) begin
          cnt <= '0;
          is_div <= op[1];
          sign_a <= signed_op & inA[N-1];
          sign_b <= signed_op & inB[N-1];
          a_raw <= inA;
          a_mag <= in_a_mag;
          b_mag <= in_b_mag;
          rem <= '0;
          q <= op[1] ? in_a_mag : in_b_mag;
        end
      end else if (state == CALC) begin
        cnt <= cnt + 1'b1;
        rem <= is_div ? (d_ge ? d_diff : d_shift[N-1:0]) : m_sum[N:1];
        q <= is_div ? {q[N-2:0], d_ge} : {m_sum[0], q[N-1:1]};
      end else begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end
`ifdef MDU_DIV_ZERO_FLAG_EN
  always_ff @(posedge clock or negedge reset)
    if (!reset) div_zero <= 1'b0;
    else if (state == FINISH) div_zero <= is_div & b_zero;
`endif
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;
  logic clock = 1'b0, reset = 1'b0, start = 1'b0, hi_wen = 1'b0, lo_wen = 1'b0;
  logic [1:0] op = '0;
  logic [31:0] inA = '0, inB = '0, wd = '0;
  logic busy, done;
  logic [31:0] hi, lo;
`ifdef MDU_DIV_ZERO_FLAG_EN
  logic div_zero;
`endif
  int n_checks = 0, n_fail = 0, n_done = 0;
  logic [63:0] sb_q[$];

  mult_div_unit #(.N(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .inA(inA), .inB(inB),
    .hi_wen(hi_wen), .lo_wen(lo_wen), .wd(wd), .busy(busy), .done(done), .hi(hi), .lo(lo)
`ifdef MDU_DIV_ZERO_FLAG_EN
    , .div_zero(div_zero)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, qq, rr;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (o[1] && b == 32'd0) return {a, 32'hFFFFFFFF};
    case (o)
      2'd0: return 64'(sa * sb);
      2'd1: return ua * ub;
      2'd2: begin
        qq = sa / sb;
        rr = sa % sb;
        return {rr[31:0], qq[31:0]};
      end
      default: return {32'(ua % ub), 32'(ua / ub)};
    endcase
  endfunction

  always @(posedge clock) begin
    #1;
    if (done) begin
      n_done++;
      if (sb_q.size() == 0) check("unexpected_done", 64'(sb_q.size()), 64'd1);
      else check("hi_lo", {hi, lo}, sb_q.pop_front());
    end
  end

  task automatic wait_done();
    int k = 0;
    while (!done && k < 40) begin
      @(posedge clock);
      #1;
      k++;
    end
    check("done_seen", 64'(done), 64'd1);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int k = 0;
    @(negedge clock);
    op = o; inA = a; inB = b; start = 1'b1;
    sb_q.push_back(model(o, a, b));
    @(posedge clock);
    #1;
    start = 1'b0; inA = $urandom; inB = $urandom; op = 2'($urandom);
    check("busy_after_accept", 64'(busy), 64'd1);
    while (!done && k < 40) begin
      @(posedge clock);
      #1;
      k++;
    end
    check("latency", 64'(k), 64'd33);
    check("busy_at_done", 64'(busy), 64'd0);
    @(posedge clock);
    #1;
    check("done_pulse_end", 64'(done), 64'd0);
  endtask

  initial begin
    logic [31:0] h0, l0;
    int d0;
    #2;
    check("reset_hi_lo", {hi, lo}, 64'd0);
    check("reset_busy_done", {62'd0, busy, done}, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    lo_wen = 1'b1; wd = 32'hAAAA5555;
    @(posedge clock);
    #1;
    lo_wen = 1'b0;
    check("mtlo_idle", 64'(lo), 64'hAAAA5555);
    @(negedge clock);
    hi_wen = 1'b1; wd = 32'h12345678;
    @(posedge clock);
    #1;
    hi_wen = 1'b0;
    check("mthi_idle", 64'(hi), 64'h12345678);
    check("mthi_lo_kept", 64'(lo), 64'hAAAA5555);
    @(negedge clock);
    op = 2'd0; inA = 32'hFFFFFFFD; inB = 32'd7; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("abort_busy_done", {62'd0, busy, done}, 64'd0);
    check("abort_hi_lo", {hi, lo}, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("multu_max", {hi, lo}, 64'hFFFFFFFE_00000001);
    run_op(2'd0, 32'hFFFFFFFD, 32'd7);
    check("mult_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    run_op(2'd2, 32'hFFFFFFF9, 32'd2);
    check("div_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF);
    check("div_overflow", {hi, lo}, 64'h00000000_80000000);
    run_op(2'd3, 32'd100, 32'd0);
    check("divu_zero", {hi, lo}, 64'h00000064_FFFFFFFF);
`ifdef MDU_DIV_ZERO_FLAG_EN
    check("div_zero_set", 64'(div_zero), 64'd1);
`endif
    run_op(2'd2, 32'hFFFFFF00, 32'd0);
    check("div_zero_signed", {hi, lo}, 64'hFFFFFF00_FFFFFFFF);
    @(negedge clock);
    op = 2'd3; inA = 32'd100; inB = 32'd7; start = 1'b1; hi_wen = 1'b1; wd = 32'hCAFEF00D;
    sb_q.push_back(model(2'd3, 32'd100, 32'd7));
    @(posedge clock);
    #1;
    start = 1'b0; hi_wen = 1'b0;
    check("mthi_with_start", 64'(hi), 64'hCAFEF00D);
    wait_done();
    check("divu_100_7", {hi, lo}, 64'h00000002_0000000E);
`ifdef MDU_DIV_ZERO_FLAG_EN
    check("div_zero_clear", 64'(div_zero), 64'd0);
`endif
    for (int i = 0; i < 12; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = (i % 5 == 4) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      run_op(2'(i % 4), ra, rb);
    end
    h0 = hi; l0 = lo; d0 = n_done;
    @(negedge clock);
    op = 2'd3; inA = 32'd1000; inB = 32'd3; start = 1'b1;
    sb_q.push_back(model(2'd3, 32'd1000, 32'd3));
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    op = 2'd0; inA = 32'd5; inB = 32'd5; start = 1'b1; hi_wen = 1'b1; lo_wen = 1'b1; wd = 32'h12345678;
    @(posedge clock);
    #1;
    start = 1'b0; hi_wen = 1'b0; lo_wen = 1'b0;
    check("mthi_busy", 64'(hi), 64'(h0));
    check("mtlo_busy", 64'(lo), 64'(l0));
    wait_done();
    repeat (40) @(posedge clock);
    #1;
    check("single_done", 64'(n_done - d0), 64'd1);
    check("start_not_queued", 64'(busy), 64'd0);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
